// File: rtl/sprite_ctrl_pkg.sv
// Shared types, constants and helpers for the sprite motion controller:
// FSM states, command framing and the per-axis bounce step.
package sprite_ctrl_pkg;

  localparam int         POS_W       = 10;
  localparam int         CMD_BYTES   = 5;
  localparam logic [7:0] CMD_SET_POS = 8'hA0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic             dir_neg;
    logic [POS_W-1:0] pos;
  } axis_t;

  // One bounce step on a single axis; arithmetic is one bit wider than the position.
  function automatic axis_t axis_step(input logic [POS_W-1:0] pos, input logic dir_neg,
                                      input logic [POS_W:0] max, input logic [POS_W:0] step);
    axis_t          r;
    logic [POS_W:0] p;
    p         = {1'b0, pos};
    r.dir_neg = dir_neg;
    r.pos     = pos;
    if (!dir_neg) begin
      if (p + step >= max) begin
        r.pos     = max[POS_W-1:0];
        r.dir_neg = 1'b1;
      end else begin
        p     = p + step;
        r.pos = p[POS_W-1:0];
      end
    end else begin
      if (p <= step) begin
        r.pos     = '0;
        r.dir_neg = 1'b0;
      end else begin
        p     = p - step;
        r.pos = p[POS_W-1:0];
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [POS_W-1:0] x,
                                          input logic [POS_W-1:0] y);
    case (idx)
      3'd0:    cmd_byte = CMD_SET_POS;
      3'd1:    cmd_byte = {6'b0, x[9:8]};
      3'd2:    cmd_byte = x[7:0];
      3'd3:    cmd_byte = {6'b0, y[9:8]};
      3'd4:    cmd_byte = y[7:0];
      default: cmd_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// Three-wire serial link from the motion controller to the VGA core's config input.
interface sprite_motion_ctrl_if;
  logic sclk;
  logic mosi;
  logic cs_n;

  modport master (output sclk, output mosi, output cs_n);
  modport slave  (input  sclk, input  mosi, input  cs_n);
endinterface

// File: rtl/spi_byte_tx.sv
// SPI mode-0 byte transmitter: SCLK divider, MSB-first shifter and bit counter.
module spi_byte_tx #(
  parameter int SCLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       ready_o
);

  localparam int            CW       = $clog2(SCLK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(SCLK_DIV - 1);

  logic          active_q;
  logic          sclk_q;
  logic [CW-1:0] div_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          toggle;

  // Handshake: load_i captures data_i at the clock edge, restarting any byte in flight.
  // ready_o is high for exactly the cycle whose closing edge is the 8th falling SCLK edge,
  // so a load issued in that cycle follows on with no gap.
  assign toggle  = active_q && (div_q == DIV_LAST);
  assign ready_o = toggle && sclk_q && (bit_q == 3'd7);
  assign sclk_o  = sclk_q;
  assign mosi_o  = sh_q[7];

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
    end else if (load_i) begin
      active_q <= 1'b1;
      sclk_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      sh_q     <= data_i;
    end else if (active_q) begin
      if (toggle) begin
        div_q  <= '0;
        sclk_q <= ~sclk_q;
        if (sclk_q) begin
          sh_q  <= {sh_q[6:0], 1'b0};
          bit_q <= bit_q + 3'd1;
          if (bit_q == 3'd7) active_q <= 1'b0;
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame bouncing sprite scheduler that sends the new position as a 5-byte SPI command.
// Optional button control (pause / reverse) is enabled by defining SPRITE_CTRL_BTN_EN.
module sprite_motion_ctrl
  import sprite_ctrl_pkg::*;
#(
  parameter int SCREEN_W = 800,
  parameter int SCREEN_H = 600,
  parameter int SPRITE_W = 96,
  parameter int SPRITE_H = 96,
  parameter int STEP     = 2,
  parameter int SCLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vsync_i,
  input  logic [1:0]           btn_i,
  sprite_motion_ctrl_if.master spi,
  output logic                 busy_o,
  output logic                 overrun_o,
  output logic [POS_W-1:0]     pos_x_o,
  output logic [POS_W-1:0]     pos_y_o,
  output state_t               state_o
);

  localparam logic [POS_W:0] XMAX   = (POS_W+1)'(SCREEN_W - SPRITE_W);
  localparam logic [POS_W:0] YMAX   = (POS_W+1)'(SCREEN_H - SPRITE_H);
  localparam logic [POS_W:0] STEP_L = (POS_W+1)'(STEP);

  state_t           state_q, state_d;
  logic             vsync_q, overrun_q, cs_n_q;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic             dirx_q, dirx_d, diry_q, diry_d;
  logic [2:0]       byte_q, byte_d;
  logic             frame_start, tx_load, tx_ready;
  logic [7:0]       tx_data;
  logic             rev_w, hold_w;
  axis_t            ax, ay;

  assign frame_start = vsync_q & ~vsync_i;

`ifdef SPRITE_CTRL_BTN_EN
  logic btn1_q, rev_pend_q;

  assign rev_w  = rev_pend_q;
  assign hold_w = btn_i[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      btn1_q     <= 1'b0;
      rev_pend_q <= 1'b0;
    end else begin
      btn1_q <= btn_i[1];
      if (btn_i[1] && !btn1_q)      rev_pend_q <= 1'b1;
      else if (state_q == ST_UPDATE) rev_pend_q <= 1'b0;
    end
  end
`else
  logic unused_btn;
  assign unused_btn = ^btn_i;
  assign rev_w      = 1'b0;
  assign hold_w     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dirx_d  = dirx_q;
    diry_d  = diry_q;
    byte_d  = byte_q;
    tx_load = 1'b0;
    ax      = axis_step(x_q, dirx_q ^ rev_w, XMAX, STEP_L);
    ay      = axis_step(y_q, diry_q ^ rev_w, YMAX, STEP_L);
    case (state_q)
      ST_IDLE:   if (frame_start) state_d = ST_UPDATE;
      ST_UPDATE: begin
        if (hold_w) begin
          dirx_d = dirx_q ^ rev_w;
          diry_d = diry_q ^ rev_w;
        end else begin
          x_d    = ax.pos;
          dirx_d = ax.dir_neg;
          y_d    = ay.pos;
          diry_d = ay.dir_neg;
        end
        byte_d  = 3'd0;
        tx_load = 1'b1;
        state_d = ST_LOAD;
      end
      ST_LOAD:   state_d = ST_SHIFT;
      ST_SHIFT:  begin
        if (tx_ready) begin
          if (byte_q == 3'(CMD_BYTES - 1)) begin
            state_d = ST_DONE;
          end else begin
            byte_d  = byte_q + 3'd1;
            tx_load = 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Byte 0 is the opcode, so the position is already final when the data bytes load.
  assign tx_data = cmd_byte(byte_d, x_q, y_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      vsync_q   <= 1'b1;
      overrun_q <= 1'b0;
      cs_n_q    <= 1'b1;
      x_q       <= '0;
      y_q       <= '0;
      dirx_q    <= 1'b0;
      diry_q    <= 1'b0;
      byte_q    <= '0;
    end else begin
      state_q <= state_d;
      vsync_q <= vsync_i;
      if (frame_start && state_q != ST_IDLE) overrun_q <= 1'b1;
      cs_n_q  <= !(state_d == ST_LOAD || state_d == ST_SHIFT);
      x_q     <= x_d;
      y_q     <= y_d;
      dirx_q  <= dirx_d;
      diry_q  <= diry_d;
      byte_q  <= byte_d;
    end
  end

  spi_byte_tx #(.SCLK_DIV(SCLK_DIV)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .load_i  (tx_load),
    .data_i  (tx_data),
    .sclk_o  (spi.sclk),
    .mosi_o  (spi.mosi),
    .ready_o (tx_ready)
  );

  assign spi.cs_n  = cs_n_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign overrun_o = overrun_q;
  assign pos_x_o   = x_q;
  assign pos_y_o   = y_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: reset, command bytes, timing, overrun, reset
// mid-transfer, buttons and bounce at both screen edges.
module tb_sprite_motion_ctrl;
  import sprite_ctrl_pkg::*;

  localparam int DIV = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync;
  logic [1:0] btn;
  logic       busy, overrun;
  logic [9:0] pos_x, pos_y;
  state_t     st;

  sprite_motion_ctrl_if spi_if ();

  sprite_motion_ctrl #(.SCLK_DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .vsync_i   (vsync),
    .btn_i     (btn),
    .spi       (spi_if),
    .busy_o    (busy),
    .overrun_o (overrun),
    .pos_x_o   (pos_x),
    .pos_y_o   (pos_y),
    .state_o   (st)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  int         timeouts = 0;
  int         rises    = 0;
  int         nbits    = 0;
  int         bc;
  logic       prev_sclk = 1'b0;
  logic [7:0] shreg     = 8'h00;
  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];

  // Serial capture on SCLK rising edges while selected.
  always @(negedge clk) begin
    if (spi_if.sclk && !prev_sclk && !spi_if.cs_n) begin
      shreg = {shreg[6:0], spi_if.mosi};
      nbits++;
      rises++;
      if (nbits == 8) begin
        cap_q.push_back(shreg);
        nbits = 0;
      end
    end
    prev_sclk = spi_if.sclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_cap();
    cap_q.delete();
    nbits = 0;
    rises = 0;
  endtask

  task automatic push_cmd(input logic [9:0] x, input logic [9:0] y);
    exp_q.push_back(8'hA0);
    exp_q.push_back({6'b0, x[9:8]});
    exp_q.push_back(x[7:0]);
    exp_q.push_back({6'b0, y[9:8]});
    exp_q.push_back(y[7:0]);
  endtask

  task automatic check_bytes(input string tag);
    logic [7:0] got;
    chk({tag, "_count"}, 32'(cap_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      got = 8'hxx;
      if (cap_q.size() > 0) got = cap_q.pop_front();
      chk({tag, "_byte"}, {24'b0, got}, {24'b0, exp_q.pop_front()});
    end
    cap_q.delete();
  endtask

  task automatic pulse_vsync();
    vsync = 1'b0;
    tick(1);
    vsync = 1'b1;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    for (int i = 0; i < 2000; i++) begin
      tick(1);
      if (!busy) break;
      cyc++;
    end
    if (busy) timeouts++;
  endtask

  task automatic frame();
    int c;
    pulse_vsync();
    wait_idle(c);
    tick(1);
  endtask

  task automatic chk_pos(input string tag, input logic [9:0] x, input logic [9:0] y);
    chk({tag, "_x"}, {22'b0, pos_x}, {22'b0, x});
    chk({tag, "_y"}, {22'b0, pos_y}, {22'b0, y});
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst   = 1'b1;
    vsync = 1'b1;
    btn   = 2'b00;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_cs_n", {31'b0, spi_if.cs_n}, 32'd1);
    chk("rst_sclk", {31'b0, spi_if.sclk}, 32'd0);
    chk("rst_mosi", {31'b0, spi_if.mosi}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_overrun", {31'b0, overrun}, 32'd0);
    chk("rst_state", 32'(st), 32'(ST_IDLE));
    chk_pos("rst_pos", 10'd0, 10'd0);

    // Single frame with cycle-level timing checks.
    clear_cap();
    pulse_vsync();
    chk("t1_busy", {31'b0, busy}, 32'd1);
    chk("t1_state", 32'(st), 32'(ST_UPDATE));
    chk("t1_cs_n", {31'b0, spi_if.cs_n}, 32'd1);
    tick(1);
    chk("t2_cs_n", {31'b0, spi_if.cs_n}, 32'd0);
    chk("t2_mosi", {31'b0, spi_if.mosi}, 32'd1);
    chk("t2_sclk", {31'b0, spi_if.sclk}, 32'd0);
    chk_pos("t2_pos", 10'd2, 10'd2);
    tick(1);
    chk("t3_sclk", {31'b0, spi_if.sclk}, 32'd0);
    tick(1);
    chk("t4_sclk", {31'b0, spi_if.sclk}, 32'd1);
    wait_idle(bc);
    chk("busy_cycles", 32'(bc + 4), 32'(2 + 80 * DIV));
    chk("f1_cs_n", {31'b0, spi_if.cs_n}, 32'd1);
    chk("f1_rises", 32'(rises), 32'd40);
    push_cmd(10'd2, 10'd2);
    check_bytes("f1");
    tick(1);

    // Second frame start while busy.
    clear_cap();
    pulse_vsync();
    tick(98);
    chk("ovr_before", {31'b0, overrun}, 32'd0);
    pulse_vsync();
    chk("ovr_set", {31'b0, overrun}, 32'd1);
    wait_idle(bc);
    tick(1);
    chk("ovr_rises", 32'(rises), 32'd40);
    chk("ovr_sticky", {31'b0, overrun}, 32'd1);
    chk_pos("ovr_pos", 10'd4, 10'd4);
    push_cmd(10'd4, 10'd4);
    check_bytes("ovr");

    // Reset in the middle of the third byte.
    clear_cap();
    pulse_vsync();
    tick(80);
    chk("mid_cs_n_low", {31'b0, spi_if.cs_n}, 32'd0);
    rst = 1'b1;
    tick(1);
    chk("mid_cs_n", {31'b0, spi_if.cs_n}, 32'd1);
    chk("mid_sclk", {31'b0, spi_if.sclk}, 32'd0);
    chk("mid_busy", {31'b0, busy}, 32'd0);
    chk("mid_overrun", {31'b0, overrun}, 32'd0);
    chk_pos("mid_pos", 10'd0, 10'd0);
    rst = 1'b0;
    tick(2);
    clear_cap();
    frame();
    chk_pos("post_rst_pos", 10'd2, 10'd2);
    push_cmd(10'd2, 10'd2);
    check_bytes("post_rst");

`ifdef SPRITE_CTRL_BTN_EN
    btn = 2'b01;
    clear_cap();
    for (int i = 0; i < 3; i++) begin
      frame();
      push_cmd(10'd2, 10'd2);
    end
    chk_pos("pause_pos", 10'd2, 10'd2);
    check_bytes("pause");
    btn = 2'b00;
    for (int i = 0; i < 4; i++) frame();
    chk_pos("pre_rev_pos", 10'd10, 10'd10);
    btn = 2'b10;
    tick(2);
    btn = 2'b00;
    tick(2);
    frame();
    chk_pos("rev_pos", 10'd8, 10'd8);
`else
    btn = 2'b01;
    frame();
    chk_pos("btn_ignored_pos", 10'd4, 10'd4);
    btn = 2'b10;
    tick(2);
    btn = 2'b00;
    tick(2);
    frame();
    chk_pos("rev_ignored_pos", 10'd6, 10'd6);
`endif

    // Bounce at YMAX (504) and XMAX (704).
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    for (n = 1; n <= 353; n++) begin
      if (n == 352) clear_cap();
      frame();
      if (n == 252) chk_pos("f252", 10'd504, 10'd504);
      if (n == 253) chk_pos("f253", 10'd506, 10'd502);
      if (n == 352) begin
        chk_pos("f352", 10'd704, 10'd304);
        push_cmd(10'd704, 10'd304);
        check_bytes("f352");
      end
      if (n == 353) chk_pos("f353", 10'd702, 10'd302);
    end
    chk("idle_timeouts", 32'(timeouts), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
